// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall controller: ID/EX/MEM hazard inputs
// and the pipeline-register enables, flushes, MDU handshake and stall counter.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             use_rs_ID;
  logic             use_rt_ID;
  logic             branch_ID;
  logic             taken_ID;
  logic             mdu_start_ID;
  logic             mdu_read_ID;
  logic [4:0]       RW_EX;
  logic             RegWrite_EX;
  logic             MemRead_EX;
  logic [4:0]       RW_MEM;
  logic             MemRead_MEM;
  logic             PC_write;
  logic             IFID_write;
  logic             IDEX_flush;
  logic             IFID_flush;
  logic             mdu_go;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, branch_ID, taken_ID,
           mdu_start_ID, mdu_read_ID, RW_EX, RegWrite_EX, MemRead_EX,
           RW_MEM, MemRead_MEM,
    output PC_write, IFID_write, IDEX_flush, IFID_flush, mdu_go, mdu_busy,
           stall_cycles
  );

  modport master (
    output rs_ID, rt_ID, use_rs_ID, use_rt_ID, branch_ID, taken_ID,
           mdu_start_ID, mdu_read_ID, RW_EX, RegWrite_EX, MemRead_EX,
           RW_MEM, MemRead_MEM,
    input  PC_write, IFID_write, IDEX_flush, IFID_flush, mdu_go, mdu_busy,
           stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use, ID-branch operand and
// MDU sequencing stalls, taken-branch flush, and a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_stall_ctrl_if.slave hs
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic match_e, match_m;
  logic load_use, br_ex, br_mem, mdu_hz, stall;
  logic busy, go;

  always_comb begin
    match_e = (hs.RW_EX != 5'd0) &&
              ((hs.use_rs_ID && (hs.RW_EX == hs.rs_ID)) ||
               (hs.use_rt_ID && (hs.RW_EX == hs.rt_ID)));
    match_m = (hs.RW_MEM != 5'd0) &&
              ((hs.use_rs_ID && (hs.RW_MEM == hs.rs_ID)) ||
               (hs.use_rt_ID && (hs.RW_MEM == hs.rt_ID)));

    // Busy is masked by reset so the whole reset cycle reads as idle.
    busy     = (state_q == BUSY) && !rst;
    load_use = hs.MemRead_EX && match_e;
    br_ex    = hs.branch_ID && hs.RegWrite_EX && match_e;
    br_mem   = hs.branch_ID && hs.MemRead_MEM && match_m;
    mdu_hz   = busy && (hs.mdu_start_ID || hs.mdu_read_ID);
    stall    = load_use || br_ex || br_mem || mdu_hz;
    go       = !rst && !stall && hs.mdu_start_ID;
  end

  always_comb begin
    hs.PC_write   = 1'b1;
    hs.IFID_write = 1'b1;
    hs.IDEX_flush = 1'b0;
    hs.IFID_flush = hs.branch_ID && hs.taken_ID;
    hs.mdu_go     = go;
    if (rst) begin
      hs.PC_write   = 1'b0;
      hs.IFID_write = 1'b0;
      hs.IDEX_flush = 1'b1;
      hs.IFID_flush = 1'b1;
    end else if (stall) begin
      // A taken branch held by a stall flushes once the stall clears.
      hs.PC_write   = 1'b0;
      hs.IFID_write = 1'b0;
      hs.IDEX_flush = 1'b1;
      hs.IFID_flush = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = BUSY;
          cnt_d   = 4'(MDU_LAT);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hs.mdu_busy     = busy;
  assign hs.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: vector table for single-cycle hazards,
// hand-written sequences for MDU occupancy and reset during an MDU operation.
module tb_hazard_stall_ctrl;

  localparam int CNT_W   = 32;
  localparam int MDU_LAT = 4;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       branch;
    logic       taken;
    logic       mstart;
    logic       mread;
    logic [4:0] rw_ex;
    logic       regwrite_ex;
    logic       memread_ex;
    logic [4:0] rw_mem;
    logic       memread_mem;
    logic       e_stall;
    logic       e_ifidf;
    logic       e_go;
    logic       e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hs  (hif.slave)
  );

  int total = 0;
  int bad   = 0;
  int exp_stalls = 0;
  bit cnt_valid  = 1'b0;
  vec_t tbl[23];

  function automatic vec_t blank();
    vec_t v;
    v.rst = 1'b0; v.rs = 5'd0; v.rt = 5'd0; v.use_rs = 1'b0; v.use_rt = 1'b0;
    v.branch = 1'b0; v.taken = 1'b0; v.mstart = 1'b0; v.mread = 1'b0;
    v.rw_ex = 5'd0; v.regwrite_ex = 1'b0; v.memread_ex = 1'b0;
    v.rw_mem = 5'd0; v.memread_mem = 1'b0;
    v.e_stall = 1'b0; v.e_ifidf = 1'b0; v.e_go = 1'b0; v.e_busy = 1'b0;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst                = v.rst;
    hif.rs_ID          = v.rs;
    hif.rt_ID          = v.rt;
    hif.use_rs_ID      = v.use_rs;
    hif.use_rt_ID      = v.use_rt;
    hif.branch_ID      = v.branch;
    hif.taken_ID       = v.taken;
    hif.mdu_start_ID   = v.mstart;
    hif.mdu_read_ID    = v.mread;
    hif.RW_EX          = v.rw_ex;
    hif.RegWrite_EX    = v.regwrite_ex;
    hif.MemRead_EX     = v.memread_ex;
    hif.RW_MEM         = v.rw_mem;
    hif.MemRead_MEM    = v.memread_mem;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    #1;
    compare({tag, ".PC_write"},   32'(hif.PC_write),   32'(!v.e_stall));
    compare({tag, ".IFID_write"}, 32'(hif.IFID_write), 32'(!v.e_stall));
    compare({tag, ".IDEX_flush"}, 32'(hif.IDEX_flush), 32'(v.e_stall));
    compare({tag, ".IFID_flush"}, 32'(hif.IFID_flush), 32'(v.e_ifidf));
    compare({tag, ".mdu_go"},     32'(hif.mdu_go),     32'(v.e_go));
    compare({tag, ".mdu_busy"},   32'(hif.mdu_busy),   32'(v.e_busy));
    if (cnt_valid)
      compare({tag, ".stall_cycles"}, hif.stall_cycles, 32'(exp_stalls));
    if (v.rst) begin
      exp_stalls = 0;
      cnt_valid  = 1'b1;
    end else if (v.e_stall) begin
      exp_stalls++;
    end
  endtask

  task automatic runStep(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  initial begin
    vec_t v;

    for (int i = 0; i < 23; i++) tbl[i] = blank();
    // Reset held two cycles, then release idle
    tbl[0].rst = 1; tbl[0].e_stall = 1; tbl[0].e_ifidf = 1;
    tbl[1].rst = 1; tbl[1].e_stall = 1; tbl[1].e_ifidf = 1;
    // Load-use on rs, then cleared, then the same with $0
    tbl[3].memread_ex = 1; tbl[3].regwrite_ex = 1; tbl[3].rw_ex = 8;
    tbl[3].rs = 8; tbl[3].use_rs = 1; tbl[3].e_stall = 1;
    tbl[4].rs = 8; tbl[4].use_rs = 1;
    tbl[5].memread_ex = 1; tbl[5].regwrite_ex = 1; tbl[5].rw_ex = 0;
    tbl[5].rs = 0; tbl[5].use_rs = 1;
    // Taken branch on $9 behind a load: EX then MEM stall, then flush
    tbl[7].branch = 1; tbl[7].taken = 1; tbl[7].rt = 9; tbl[7].use_rt = 1;
    tbl[7].memread_ex = 1; tbl[7].regwrite_ex = 1; tbl[7].rw_ex = 9; tbl[7].e_stall = 1;
    tbl[8].branch = 1; tbl[8].taken = 1; tbl[8].rt = 9; tbl[8].use_rt = 1;
    tbl[8].memread_mem = 1; tbl[8].rw_mem = 9; tbl[8].e_stall = 1;
    tbl[9].branch = 1; tbl[9].taken = 1; tbl[9].rt = 9; tbl[9].use_rt = 1;
    tbl[9].e_ifidf = 1;
    // Branch behind an ALU write to $5, then non-branch with the same operands
    tbl[11].branch = 1; tbl[11].rs = 5; tbl[11].use_rs = 1;
    tbl[11].regwrite_ex = 1; tbl[11].rw_ex = 5; tbl[11].e_stall = 1;
    tbl[12].branch = 1; tbl[12].rs = 5; tbl[12].use_rs = 1;
    tbl[13].rs = 5; tbl[13].use_rs = 1; tbl[13].regwrite_ex = 1; tbl[13].rw_ex = 5;
    // Branch reading $0 behind a write of $0
    tbl[14].branch = 1; tbl[14].use_rs = 1; tbl[14].regwrite_ex = 1;
    // Load matching an operand the instruction does not read
    tbl[15].memread_ex = 1; tbl[15].regwrite_ex = 1; tbl[15].rw_ex = 7; tbl[15].rs = 7;
    // Load in MEM: stalls a branch, not an ordinary reader
    tbl[16].branch = 1; tbl[16].rs = 12; tbl[16].use_rs = 1;
    tbl[16].memread_mem = 1; tbl[16].rw_mem = 12; tbl[16].e_stall = 1;
    tbl[17].rs = 12; tbl[17].use_rs = 1; tbl[17].memread_mem = 1; tbl[17].rw_mem = 12;
    tbl[18].branch = 1;
    // Load-use on rt
    tbl[19].rt = 3; tbl[19].use_rt = 1; tbl[19].memread_ex = 1;
    tbl[19].regwrite_ex = 1; tbl[19].rw_ex = 3; tbl[19].e_stall = 1;
    // MDU start held off by a load-use stall
    tbl[21].mstart = 1; tbl[21].rs = 4; tbl[21].use_rs = 1; tbl[21].memread_ex = 1;
    tbl[21].regwrite_ex = 1; tbl[21].rw_ex = 4; tbl[21].e_stall = 1;

    for (int i = 0; i < 23; i++) runStep(tbl[i], $sformatf("vec%0d", i));

    // MDU start then mfhi held: stalled exactly while busy
    v = blank(); v.mstart = 1; v.e_go = 1;
    runStep(v, "mdu_a0");
    for (int i = 1; i <= MDU_LAT; i++) begin
      v = blank(); v.mread = 1; v.e_stall = 1; v.e_busy = 1;
      runStep(v, $sformatf("mdu_a%0d", i));
    end
    v = blank(); v.mread = 1;
    runStep(v, "mdu_a_release");
    runStep(blank(), "mdu_a_idle");

    // Second start while busy waits for IDLE
    v = blank(); v.mstart = 1; v.e_go = 1;
    runStep(v, "mdu_b0");
    for (int i = 1; i <= MDU_LAT; i++) begin
      v = blank(); v.mstart = 1; v.e_stall = 1; v.e_busy = 1;
      runStep(v, $sformatf("mdu_b%0d", i));
    end
    v = blank(); v.mstart = 1; v.e_go = 1;
    runStep(v, "mdu_b_go2");
    for (int i = 1; i <= MDU_LAT; i++) begin
      v = blank(); v.e_busy = 1;
      runStep(v, $sformatf("mdu_b_busy2_%0d", i));
    end
    runStep(blank(), "mdu_b_done");

    // Reset two cycles after mdu_go abandons the operation
    v = blank(); v.mstart = 1; v.e_go = 1;
    runStep(v, "mdu_c0");
    v = blank(); v.e_busy = 1;
    runStep(v, "mdu_c1");
    v = blank(); v.rst = 1; v.e_stall = 1; v.e_ifidf = 1;
    runStep(v, "mdu_c_rst");
    v = blank(); v.mstart = 1; v.e_go = 1;
    runStep(v, "mdu_c_restart");
    for (int i = 1; i <= MDU_LAT; i++) begin
      v = blank(); v.e_busy = 1;
      runStep(v, $sformatf("mdu_c_busy%0d", i));
    end
    runStep(blank(), "mdu_c_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
